ft600_loopback_bridge: RTL and testbench

- FT600 245-synchronous-FIFO-mode bridge (16-bit bus) with an internal synchronous FIFO, clocked by the FT600 output clock.
- Words read from the FT600 (host→FPGA) are stored with their byte enables, then written back to the FT600 (FPGA→host) in the same order.
- Used as the loopback and bring-up block for the USB3 link.

---
 rtl/ft600_loopback_bridge_if.sv | 45 ++++
 rtl/ft600_loopback_bridge.sv | 167 ++++++++++++++++
 tb/tb_ft600_loopback_bridge.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft600_loopback_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : ft600_loopback_bridge_if
//  Description : FT600 245-synchronous-FIFO control strobes and handshake
//                flags. The FPGA side uses the master modport. The FT600
//                (or a model of it) uses the slave modport.
//                  ftdi_rxf_n    FT600 -> FPGA  low = data available for FPGA
//                  ftdi_txe_n    FT600 -> FPGA  low = FT600 can accept data
//                  ftdi_oe_n     FPGA  -> FT600 bus output enable, active low
//                  ftdi_rd_n     FPGA  -> FT600 read strobe, active low
//                  ftdi_wr_n     FPGA  -> FT600 write strobe, active low
//                  ftdi_resetn   FPGA  -> FT600 RESET_N
//                  ftdi_wakeupn  FPGA  -> FT600 WAKEUP_N
//  Revision    : 1.0  initial release
// ============================================================================
interface ft600_loopback_bridge_if;
    logic ftdi_rxf_n;
    logic ftdi_txe_n;
    logic ftdi_oe_n;
    logic ftdi_rd_n;
    logic ftdi_wr_n;
    logic ftdi_resetn;
    logic ftdi_wakeupn;

    modport master (
        input  ftdi_rxf_n,
        input  ftdi_txe_n,
        output ftdi_oe_n,
        output ftdi_rd_n,
        output ftdi_wr_n,
        output ftdi_resetn,
        output ftdi_wakeupn
    );

    modport slave (
        output ftdi_rxf_n,
        output ftdi_txe_n,
        input  ftdi_oe_n,
        input  ftdi_rd_n,
        input  ftdi_wr_n,
        input  ftdi_resetn,
        input  ftdi_wakeupn
    );
endinterface
`default_nettype wire

// File: rtl/ft600_loopback_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : ft600_loopback_bridge
//  Description : FT600 245-synchronous-FIFO bridge (16-bit bus) with an
//                internal 2**ADDR_W entry FIFO. Words read from the FT600
//                are stored with their byte enables. They are then written
//                back to the FT600 in the same order (USB3 loopback).
//  Ports       : ftdi_clk    FT600 clock, the only clock domain
//                rst_n       synchronous reset, ACTIVE HIGH despite its name
//                ftdi        control strobes / flags (interface, master side)
//                ftdi_data   16-bit bidirectional data bus
//                ftdi_be     2-bit bidirectional byte enables
//                fifo_full   internal FIFO full
//                fifo_empty  internal FIFO empty
//                fifo_count  number of stored entries (0..2**ADDR_W)
//  Revision    : 1.0  initial release
// ============================================================================
module ft600_loopback_bridge #(
    parameter int ADDR_W = 4
) (
    input  wire logic               ftdi_clk,
    input  wire logic               rst_n,
    ft600_loopback_bridge_if.master ftdi,
    inout  wire [15:0]              ftdi_data,
    inout  wire [1:0]               ftdi_be,
    output logic                    fifo_full,
    output logic                    fifo_empty,
    output logic [ADDR_W:0]         fifo_count
);

    localparam int                c_depth   = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   c_cnt_max = (ADDR_W + 1)'(c_depth);
    localparam logic [ADDR_W:0]   c_cnt_one = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   c_cnt_lst = c_cnt_max - c_cnt_one;
    localparam logic [ADDR_W-1:0] c_ptr_one = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RX_OE = 2'd1,
        RX_RD = 2'd2,
        TX    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [17:0]         mem_q [0:c_depth-1];

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_oe_n;
    logic                w_rd_n;
    logic                w_wr_n;
    logic                w_drive;
    logic [17:0]         w_head;

    assign w_full  = (count_q == c_cnt_max);
    assign w_empty = (count_q == '0);

    // First-word fall-through: the head is visible without a read cycle.
    assign w_head  = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Control FSM: next state and bus strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        w_oe_n  = 1'b1;
        w_rd_n  = 1'b1;
        w_wr_n  = 1'b1;
        w_drive = 1'b0;
        w_push  = 1'b0;
        w_pop   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Receive wins when both directions are ready.
                if (!ftdi.ftdi_rxf_n && !w_full) begin
                    state_d = RX_OE;
                end else if (!ftdi.ftdi_txe_n && !w_empty) begin
                    state_d = TX;
                end
            end
            RX_OE: begin
                // One turnaround cycle: FT600 takes the bus before any strobe.
                w_oe_n  = 1'b0;
                state_d = RX_RD;
            end
            RX_RD: begin
                w_oe_n = 1'b0;
                // Strobe suppressed combinationally once there is no space.
                w_rd_n = w_full;
                w_push = !ftdi.ftdi_rxf_n && !w_full;
                if (ftdi.ftdi_rxf_n || w_full || (w_push && count_q == c_cnt_lst)) begin
                    state_d = IDLE;
                end
            end
            TX: begin
                w_drive = 1'b1;
                w_wr_n  = !(!ftdi.ftdi_txe_n && !w_empty);
                w_pop   = !w_wr_n;
                if (ftdi.ftdi_txe_n || w_empty || (w_pop && count_q == c_cnt_one)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping. Push and pop are mutually exclusive because the
    // FSM is never in a receive and a transmit state at once.
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
            count_d  = count_q + c_cnt_one;
        end else if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
            count_d  = count_q - c_cnt_one;
        end
    end

    always_ff @(posedge ftdi_clk) begin
        if (rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset. Clearing the pointers discards the contents.
    always_ff @(posedge ftdi_clk) begin
        if (w_push && !rst_n) begin
            mem_q[wr_ptr_q] <= {ftdi_be, ftdi_data};
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The bus is driven only in TX, where oe_n is always high.
    // ------------------------------------------------------------------
    assign ftdi_data = w_drive ? w_head[15:0]  : 16'hzzzz;
    assign ftdi_be   = w_drive ? w_head[17:16] : 2'bzz;

    assign ftdi.ftdi_oe_n    = w_oe_n;
    assign ftdi.ftdi_rd_n    = w_rd_n;
    assign ftdi.ftdi_wr_n    = w_wr_n;
    assign ftdi.ftdi_resetn  = ~rst_n;
    assign ftdi.ftdi_wakeupn = 1'b1;

    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;
    assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_ft600_loopback_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ft600_loopback_bridge
//  Description : Self-checking bench for ft600_loopback_bridge. A simple
//                FT600 model supplies words and collects written words. An
//                ordered queue serves as the reference FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ft600_loopback_bridge;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ft600_loopback_bridge_if bus_if ();

    wire  [15:0]       ftdi_data;
    wire  [1:0]        ftdi_be;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W:0]   fifo_count;

    // FT600 side: drives the bus while oe_n is low. probe_en lets the bench
    // drive a marker to show that the FPGA has released the bus.
    logic [15:0] host_data;
    logic [1:0]  host_be;
    logic        probe_en;
    assign ftdi_data = (!bus_if.ftdi_oe_n || probe_en) ? host_data : 16'hzzzz;
    assign ftdi_be   = (!bus_if.ftdi_oe_n || probe_en) ? host_be   : 2'bzz;

    ft600_loopback_bridge #(.ADDR_W(ADDR_W)) dut (
        .ftdi_clk   (clk),
        .rst_n      (rst_n),
        .ftdi       (bus_if),
        .ftdi_data  (ftdi_data),
        .ftdi_be    (ftdi_be),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count)
    );

    int errors = 0;
    int checks = 0;

    logic [17:0] stim[$];
    logic [17:0] model[$];
    logic [17:0] tx_got[$];
    int          rd_while_full;
    int          bus_conflicts;

    logic [15:0] fixed_words [0:7] = '{16'h3130, 16'h3332, 16'h3534, 16'h3736,
                                       16'h3938, 16'h6261, 16'h6463, 16'h6665};

    // FT600 host->FPGA model. A word counts as transferred at an edge where
    // rxf_n is low and rd_n is low.
    task automatic rx_run(input int n, input bit stall, output int acc,
                          output int oe_cyc, output int rd_cyc);
        logic rl;
        int   idx = 0;
        oe_cyc = -1;
        rd_cyc = -1;
        for (int c = 0; c < n * 4 + 40 && idx < n; c++) begin
            @(negedge clk);
            host_data = stim[idx][15:0];
            host_be   = stim[idx][17:16];
            bus_if.ftdi_rxf_n = stall ? ($urandom_range(0, 3) == 0) : 1'b0;
            #1;
            if (!bus_if.ftdi_oe_n && oe_cyc < 0) oe_cyc = c;
            if (!bus_if.ftdi_rd_n && rd_cyc < 0) rd_cyc = c;
            if (fifo_full && !bus_if.ftdi_rd_n) rd_while_full++;
            if (!bus_if.ftdi_wr_n) bus_conflicts++;
            rl = !bus_if.ftdi_rd_n && !bus_if.ftdi_rxf_n;
            @(posedge clk);
            if (rl) begin
                model.push_back(stim[idx]);
                idx++;
            end
        end
        acc = idx;
        @(negedge clk);
        bus_if.ftdi_rxf_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    // FT600 FPGA->host model. Collects every word strobed with wr_n low.
    task automatic tx_run(input int stop_after, input bit stall, input int budget,
                          output int nwr);
        logic wl;
        nwr = 0;
        tx_got.delete();
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            bus_if.ftdi_txe_n = stall ? ($urandom_range(0, 3) == 0) : 1'b0;
            #1;
            wl = !bus_if.ftdi_wr_n;
            if (wl) tx_got.push_back({ftdi_be, ftdi_data});
            if (!bus_if.ftdi_oe_n && (wl || !bus_if.ftdi_wr_n)) bus_conflicts++;
            @(posedge clk);
            if (wl) nwr++;
            if (stop_after > 0 && nwr == stop_after) return;
        end
        @(negedge clk);
        bus_if.ftdi_txe_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        probe_en = 1'b1; host_data = 16'hA55A; host_be = 2'b01;
        #1;
        checks++;
        if ({bus_if.ftdi_oe_n, bus_if.ftdi_rd_n, bus_if.ftdi_wr_n} !== 3'b111) begin
            errors++;
            $display("FAIL reset_strobes: got oe/rd/wr=%b expected 111",
                     {bus_if.ftdi_oe_n, bus_if.ftdi_rd_n, bus_if.ftdi_wr_n});
        end
        checks++;
        if (bus_if.ftdi_resetn !== 1'b0 || bus_if.ftdi_wakeupn !== 1'b1) begin
            errors++;
            $display("FAIL reset_pins: got resetn=%b wakeupn=%b expected 0/1",
                     bus_if.ftdi_resetn, bus_if.ftdi_wakeupn);
        end
        checks++;
        if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || fifo_count !== '0) begin
            errors++;
            $display("FAIL reset_fifo: got empty=%b full=%b count=%0d expected 1/0/0",
                     fifo_empty, fifo_full, fifo_count);
        end
        checks++;
        if (ftdi_data !== 16'hA55A || ftdi_be !== 2'b01) begin
            errors++;
            $display("FAIL reset_bus_z: got %h/%b expected released bus a55a/01",
                     ftdi_data, ftdi_be);
        end
        probe_en = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.ftdi_resetn !== 1'b1) begin
            errors++;
            $display("FAIL resetn_release: got %b expected 1", bus_if.ftdi_resetn);
        end
        @(posedge clk);
    endtask

    task automatic load_fixed();
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back({2'b11, fixed_words[i]});
    endtask

    task automatic test_receive_burst();
        int acc, oe_c, rd_c;
        load_fixed();
        model.delete();
        rx_run(8, 1'b0, acc, oe_c, rd_c);
        @(negedge clk);
        checks++;
        if (acc !== 8 || fifo_count !== 5'd8) begin
            errors++;
            $display("FAIL rx_count: got accepted=%0d count=%0d expected 8/8", acc, fifo_count);
        end
        checks++;
        if (oe_c !== 1 || rd_c !== 2) begin
            errors++;
            $display("FAIL rx_latency: got oe_cycle=%0d rd_cycle=%0d expected 1/2", oe_c, rd_c);
        end
        checks++;
        if (bus_if.ftdi_oe_n !== 1'b1 || bus_if.ftdi_rd_n !== 1'b1) begin
            errors++;
            $display("FAIL rx_idle_strobes: got oe=%b rd=%b expected 1/1",
                     bus_if.ftdi_oe_n, bus_if.ftdi_rd_n);
        end
    endtask

    task automatic test_transmit_burst();
        int nwr;
        tx_run(0, 1'b0, 30, nwr);
        checks++;
        if (nwr !== 8) begin
            errors++;
            $display("FAIL tx_writes: got %0d expected 8", nwr);
        end
        for (int i = 0; i < 8 && i < tx_got.size(); i++) begin
            checks++;
            if (tx_got[i] !== {2'b11, fixed_words[i]}) begin
                errors++;
                $display("FAIL tx_word[%0d]: got %h expected %h", i, tx_got[i], {2'b11, fixed_words[i]});
            end
        end
        model.delete();
        @(negedge clk);
        probe_en = 1'b1; host_data = 16'h0FF0; host_be = 2'b10;
        #1;
        checks++;
        if (fifo_empty !== 1'b1 || bus_if.ftdi_wr_n !== 1'b1 || bus_if.ftdi_oe_n !== 1'b1
            || ftdi_data !== 16'h0FF0 || ftdi_be !== 2'b10) begin
            errors++;
            $display("FAIL tx_end_idle: got empty=%b wr=%b oe=%b bus=%h/%b expected 1/1/1 released",
                     fifo_empty, bus_if.ftdi_wr_n, bus_if.ftdi_oe_n, ftdi_data, ftdi_be);
        end
        probe_en = 1'b0;
    endtask

    task automatic test_repeat();
        int acc, oe_c, rd_c, nwr;
        for (int r = 0; r < 2; r++) begin
            load_fixed();
            model.delete();
            rx_run(8, 1'b0, acc, oe_c, rd_c);
            #1;
            checks++;
            if (fifo_count !== 5'd8) begin
                errors++;
                $display("FAIL repeat_rx_count[%0d]: got %0d expected 8", r, fifo_count);
            end
            tx_run(0, 1'b0, 30, nwr);
            #1;
            checks++;
            if (fifo_count !== '0 || nwr !== 8) begin
                errors++;
                $display("FAIL repeat_tx[%0d]: got count=%0d writes=%0d expected 0/8", r, fifo_count, nwr);
            end
            for (int i = 0; i < tx_got.size(); i++) begin
                checks++;
                if (i >= 8 || tx_got[i] !== {2'b11, fixed_words[i]}) begin
                    errors++;
                    $display("FAIL repeat_word[%0d][%0d]: got %h", r, i, tx_got[i]);
                end
            end
        end
        model.delete();
    endtask

    task automatic test_full();
        int acc, oe_c, rd_c, nwr;
        stim.delete();
        for (int i = 0; i < 20; i++) stim.push_back({2'(i), 16'(i)});
        model.delete();
        rd_while_full = 0;
        rx_run(20, 1'b0, acc, oe_c, rd_c);
        @(negedge clk);
        checks++;
        if (acc !== DEPTH || fifo_count !== 5'd16 || fifo_full !== 1'b1) begin
            errors++;
            $display("FAIL full_store: got accepted=%0d count=%0d full=%b expected 16/16/1",
                     acc, fifo_count, fifo_full);
        end
        checks++;
        if (rd_while_full !== 0 || bus_if.ftdi_rd_n !== 1'b1) begin
            errors++;
            $display("FAIL full_rd_n: got rd_low_while_full=%0d rd=%b expected 0/1",
                     rd_while_full, bus_if.ftdi_rd_n);
        end
        tx_run(0, 1'b0, 40, nwr);
        checks++;
        if (nwr !== DEPTH || fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL full_drain: got writes=%0d empty=%b expected 16/1", nwr, fifo_empty);
        end
        for (int i = 0; i < tx_got.size(); i++) begin
            checks++;
            if (i >= DEPTH || tx_got[i] !== {2'(i), 16'(i)}) begin
                errors++;
                $display("FAIL full_word[%0d]: got %h expected %h", i, tx_got[i], {2'(i), 16'(i)});
            end
        end
        model.delete();
    endtask

    task automatic test_reset_mid_tx();
        int acc, oe_c, rd_c, nwr, late;
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(18'($urandom));
        model.delete();
        rx_run(8, 1'b0, acc, oe_c, rd_c);
        tx_run(3, 1'b0, 30, nwr);
        checks++;
        if (nwr !== 3 || tx_got.size() != 3 || tx_got[0] !== stim[0] || tx_got[2] !== stim[2]) begin
            errors++;
            $display("FAIL midtx_prefix: got writes=%0d expected 3 matching words", nwr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        probe_en = 1'b1; host_data = 16'hC33C; host_be = 2'b01;
        #1;
        checks++;
        if (bus_if.ftdi_wr_n !== 1'b1 || fifo_count !== '0 || fifo_empty !== 1'b1
            || ftdi_data !== 16'hC33C || ftdi_be !== 2'b01) begin
            errors++;
            $display("FAIL midtx_reset: got wr=%b count=%0d bus=%h/%b expected 1/0/released",
                     bus_if.ftdi_wr_n, fifo_count, ftdi_data, ftdi_be);
        end
        probe_en = 1'b0;
        rst_n = 1'b0;
        model.delete();
        late = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus_if.ftdi_txe_n = 1'b0;
            #1;
            if (!bus_if.ftdi_wr_n) late++;
        end
        checks++;
        if (late !== 0) begin
            errors++;
            $display("FAIL midtx_no_write: got %0d write cycles expected 0", late);
        end
        @(negedge clk);
        bus_if.ftdi_txe_n = 1'b1;
    endtask

    task automatic test_random();
        int acc, oe_c, rd_c, nwr, n;
        logic [17:0] exp;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, DEPTH);
            stim.delete();
            for (int i = 0; i < n; i++) stim.push_back(18'($urandom));
            model.delete();
            rx_run(n, 1'b1, acc, oe_c, rd_c);
            #1;
            checks++;
            if (acc !== n || fifo_count !== (ADDR_W + 1)'(n)) begin
                errors++;
                $display("FAIL rand_rx[%0d]: got accepted=%0d count=%0d expected %0d", it, acc, fifo_count, n);
            end
            tx_run(0, 1'b1, n * 6 + 40, nwr);
            checks++;
            if (nwr !== n || fifo_empty !== 1'b1) begin
                errors++;
                $display("FAIL rand_tx[%0d]: got writes=%0d empty=%b expected %0d/1", it, nwr, fifo_empty, n);
            end
            for (int i = 0; i < tx_got.size(); i++) begin
                exp = (model.size() > 0) ? model.pop_front() : 18'h0;
                checks++;
                if (tx_got[i] !== exp) begin
                    errors++;
                    $display("FAIL rand_word[%0d][%0d]: got %h expected %h", it, i, tx_got[i], exp);
                end
            end
        end
        checks++;
        if (bus_conflicts !== 0) begin
            errors++;
            $display("FAIL bus_conflict: got %0d cycles with bus driven under oe_n low expected 0", bus_conflicts);
        end
    endtask

    initial begin
        rst_n             = 1'b1;
        bus_if.ftdi_rxf_n = 1'b1;
        bus_if.ftdi_txe_n = 1'b1;
        probe_en          = 1'b0;
        host_data         = 16'h0;
        host_be           = 2'b00;
        rd_while_full     = 0;
        bus_conflicts     = 0;

        test_reset();
        test_receive_burst();
        test_transmit_burst();
        test_repeat();
        test_full();
        test_reset_mid_tx();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
